uarttx_feeder: RTL and testbench
================================

Name: uarttx_feeder

Overview:
- Byte FIFO plus load sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from the CPU-side console/teleprinter logic at any rate.
- Drives the transmitter's tx_load/tx_data handshake, issuing one byte each time tx_ready indicates the transmitter is idle.
- Decouples PDP-8 console output bursts from the slow serial line.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- DATA_WIDTH, 8, byte width; must match the transmitter data width.
- CW, $clog2(DEPTH)+1, derived width of count; not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- nrst  input  1  asynchronous active-low reset.
- wr_en  input  1  push wr_data this cycle.
- wr_data  input  DATA_WIDTH  byte to enqueue.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  CW  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a push was dropped.
- tx_load  output  1  one-cycle load strobe to the transmitter.
- tx_data  output  DATA_WIDTH  byte presented to the transmitter.
- tx_ready  input  1  transmitter idle/able to accept a byte.

Behaviour:
- Reset (async assert, sync-safe deassert by system): state=IDLE, rd/wr pointers=0, count=0, empty=1, full=0, overflow=0, tx_load=0, tx_data=0.
- Storage: DEPTH x DATA_WIDTH register array.
  - Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count is tracked separately.
  - full = (count==DEPTH); empty = (count==0). Both are registered-state derived, no combinational path from inputs.
- Push:
  - wr_en=1 and full=0 (value at start of cycle): write mem[wr_ptr], then wr_ptr+1.
  - wr_en=1 and full=1: data dropped, pointers unchanged, overflow=1 next cycle for exactly one cycle.
  - This applies even if a pop occurs in the same cycle; full is not bypassed.
- Sequencer states:
  - IDLE: if tx_ready=1 and empty=0, go to LOAD. At that edge, tx_data <= mem[rd_ptr], rd_ptr+1, count-1, tx_load <= 1.
  - LOAD: tx_load=1 for this single cycle; tx_data is valid and stable. Next state is WAIT_BUSY; tx_load <= 0.
  - WAIT_BUSY: remain until tx_ready=0 is sampled, then go to IDLE. This guarantees no second load before the transmitter has acknowledged busy.
- tx_data holds the last loaded byte until the next load; it never changes except on entry to LOAD.
- Latency:
  - Push into empty FIFO with tx_ready=1: wr_en at cycle N, entry visible at N+1, IDLE->LOAD decision at N+1, tx_load high in cycle N+2.
  - Back-to-back bytes: the minimum gap between tx_load pulses is LOAD + WAIT_BUSY (>=1 cycle) + IDLE (1 cycle).
- Simultaneous push and pop, not full: count unchanged, both pointers advance.
- Simultaneous push and pop with count==1: the popped entry is the old head. The new byte stays; count remains 1.
- tx_ready=1 while empty: stay in IDLE, tx_load=0.
- tx_ready deasserted by the transmitter before the load is accepted is not possible by contract. The feeder only loads after sampling tx_ready=1 in IDLE.
- Reset mid-operation (any state): immediate return to reset values. Queued bytes are discarded; a byte already loaded into the transmitter is not recalled.
- No X propagation: mem contents need no reset, but tx_data is reset to 0.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [1:0] {FEED_IDLE, FEED_LOAD, FEED_WAIT_BUSY} feed_state_t
  - localparam UART_DATA_WIDTH = 8
- One sub-module is natural: sync_fifo (storage, pointers, count, full/empty, overflow).
- uarttx_feeder instantiates sync_fifo and adds the three-state sequencer.

Test Plan:
- Reset then idle with tx_ready=1, no writes -> tx_load stays 0 for 50 cycles; empty=1, count=0, tx_data=0.
- Push 0x41 with tx_ready=1 -> tx_load high exactly one cycle two cycles after wr_en, with tx_data=0x41.
  - Model tx_ready low for 10 cycles afterwards.
  - Then empty=1 and no further tx_load.
- Push 0x48,0x49,0x0D,0x0A back-to-back; model transmitter busy 20 cycles per byte -> four tx_load pulses in order 0x48,0x49,0x0D,0x0A.
  - Each pulse occurs only after tx_ready returns high.
  - count goes 4->0.
- Hold tx_ready=0 and push 17 bytes 0x00..0x10 (DEPTH=16) -> full=1 after 16 pushes; 17th push drops and overflow pulses one cycle.
  - Release tx_ready: transmitted sequence is 0x00..0x0F.
- With count==1 and the sequencer entering LOAD, push 0x55 the same cycle -> count stays 1; next load after busy/ready cycle sends 0x55.
- Assert nrst low mid-WAIT_BUSY with 5 bytes queued -> outputs return to reset values asynchronously.
  - After release with tx_ready=1: no tx_load until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Sequencer state encoding and the serial byte width.
package uart_pkg;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_LOAD,
        FEED_WAIT_BUSY
    } feed_state_t;

    localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with separately tracked occupancy.
// A push that finds the FIFO full is dropped and flagged for one cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int DATA_WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  push;
    logic                  pop;

    // full is taken from registered count, so a same-cycle pop never frees room
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uarttx_feeder.sv
// FIFO-backed load sequencer in front of the UART transmitter.
// One byte per idle period; waits for busy before considering the next.
module uarttx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  tx_load,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready
);

    feed_state_t           state;
    feed_state_t           state_nxt;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= FEED_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FEED_IDLE: begin
                if (tx_ready && !empty) begin
                    state_nxt = FEED_LOAD;
                end
            end
            FEED_LOAD: begin
                state_nxt = FEED_WAIT_BUSY;
            end
            // hold off until the transmitter has shown it took the byte
            FEED_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_nxt = FEED_IDLE;
                end
            end
            default: begin
                state_nxt = FEED_IDLE;
            end
        endcase
    end

    always_comb begin
        pop     = (state == FEED_IDLE) && tx_ready && !empty;
        tx_load = (state == FEED_LOAD);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_data <= '0;
        end else if (pop) begin
            tx_data <= head;
        end
    end

endmodule

// File: tb/tb_uarttx_feeder.sv
// Bench for uarttx_feeder: directed scenarios plus random traffic,
// scored against a byte-queue model and a simple transmitter model.
module tb_uarttx_feeder;

    localparam int DEPTH = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          nrst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          tx_load;
    logic [7:0]    tx_data;
    logic          tx_ready;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] q[$];
    logic [7:0] sent[$];
    int         n_loads = 0;
    int         since = 100;
    int         run = 0;
    logic       prev_wr = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_nrst = 1'b0;
    logic [7:0] prev_data = 8'h00;

    bit hold_low = 1'b0;
    int busy_len = 10;
    int busy_left;
    bit seen;

    uarttx_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_load  (tx_load),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Transmitter: goes busy for busy_len cycles after accepting a load
    initial begin
        tx_ready = 1'b0;
        busy_left = 0;
        forever begin
            @(negedge clk);
            seen = tx_load;
            @(posedge clk);
            #1;
            if (seen) busy_left = busy_len;
            if (busy_left > 0) begin
                tx_ready = 1'b0;
                busy_left--;
            end else begin
                tx_ready = !hold_low;
            end
        end
    end

    // Scoreboard: prev_* hold the inputs sampled at the edge just passed
    always @(negedge clk) begin
        if (!nrst || !prev_nrst) begin
            q.delete();
            since = 100;
            run = 0;
        end else begin
            int  n;
            bit  was_full;
            n = q.size();
            was_full = (n == DEPTH);
            since++;
            if (tx_load) begin
                check("load_nonempty", n != 0, 1);
                check("load_after_ready", prev_ready, 1);
                check("load_gap", since >= 3, 1);
                if (n != 0) begin
                    check("tx_data", tx_data, q[0]);
                    void'(q.pop_front());
                end
                sent.push_back(tx_data);
                n_loads++;
                since = 0;
                run = 0;
            end else begin
                if (prev_ready && n != 0) run++;
                else run = 0;
                check("no_stall", run <= 2, 1);
            end
            if (prev_wr && !was_full) q.push_back(prev_data);
            check("count", count, q.size());
            check("empty", empty, q.size() == 0);
            check("full", full, q.size() == DEPTH);
            check("overflow", overflow, prev_wr && was_full);
        end
        prev_nrst = nrst;
        prev_wr = wr_en;
        prev_data = wr_data;
        prev_ready = tx_ready;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_loads(input int target, input int limit);
        int k = 0;
        while (n_loads < target && k < limit) begin
            tick();
            k++;
        end
        check("load_timeout", n_loads >= target, 1);
    endtask

    initial begin
        int base;
        nrst = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        tick(3);
        check("rst_tx_load", tx_load, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        nrst = 1'b1;

        // idle with transmitter ready
        base = n_loads;
        tick(50);
        check("idle_loads", n_loads - base, 0);
        check("idle_empty", empty, 1);
        check("idle_tx_data", tx_data, 0);

        // single byte latency
        busy_len = 10;
        base = n_loads;
        push(8'h41);
        check("lat_n1_load", tx_load, 0);
        check("lat_n1_count", count, 1);
        tick();
        check("lat_n2_load", tx_load, 1);
        check("lat_n2_data", tx_data, 8'h41);
        tick();
        check("lat_n3_load", tx_load, 0);
        tick(25);
        check("lat_empty", empty, 1);
        check("lat_loads", n_loads - base, 1);

        // burst of four with a slow transmitter
        busy_len = 20;
        hold_low = 1'b1;
        tick(2);
        sent.delete();
        base = n_loads;
        push(8'h48);
        push(8'h49);
        push(8'h0D);
        push(8'h0A);
        check("burst_count", count, 4);
        @(negedge clk);
        hold_low = 1'b0;
        wait_loads(base + 4, 300);
        tick(25);
        check("burst_n", sent.size(), 4);
        if (sent.size() == 4) begin
            check("burst_b0", sent[0], 8'h48);
            check("burst_b1", sent[1], 8'h49);
            check("burst_b2", sent[2], 8'h0D);
            check("burst_b3", sent[3], 8'h0A);
        end
        check("burst_count_end", count, 0);

        // fill, overflow, then drain
        hold_low = 1'b1;
        tick(2);
        sent.delete();
        base = n_loads;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        push(8'h10);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 16);
        tick();
        check("ovf_clear", overflow, 0);
        busy_len = 3;
        @(negedge clk);
        hold_low = 1'b0;
        wait_loads(base + 16, 400);
        tick(10);
        check("drain_n", sent.size(), 16);
        for (int i = 0; i < 16 && i < sent.size(); i++)
            check("drain_byte", sent[i], i);

        // push in the same cycle as the pop of the last entry
        hold_low = 1'b1;
        tick(2);
        sent.delete();
        base = n_loads;
        push(8'hAA);
        tick();
        check("pp_pre_count", count, 1);
        @(negedge clk);
        hold_low = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        check("pp_load", tx_load, 1);
        check("pp_data", tx_data, 8'hAA);
        check("pp_count", count, 1);
        wait_loads(base + 2, 100);
        check("pp_n", sent.size() >= 2, 1);
        if (sent.size() >= 2) check("pp_second", sent[1], 8'h55);
        tick(10);

        // async reset while waiting for busy to clear
        hold_low = 1'b1;
        busy_len = 20;
        tick(2);
        base = n_loads;
        for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
        @(negedge clk);
        hold_low = 1'b0;
        wait_loads(base + 1, 50);
        tick(2);
        check("mid_count", count, 5);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_tx_load", tx_load, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_overflow", overflow, 0);
        tick(2);
        nrst = 1'b1;
        base = n_loads;
        tick(40);
        check("post_rst_loads", n_loads - base, 0);
        check("post_rst_empty", empty, 1);

        // random traffic
        for (int i = 0; i < 1200; i++) begin
            busy_len = $urandom_range(1, 6);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 99) == 0) hold_low = !hold_low;
            tick();
        end
        wr_en = 1'b0;
        hold_low = 1'b0;
        for (int k = 0; k < 600 && q.size() > 0; k++) tick();
        check("rand_drained", q.size(), 0);
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
